// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - single-port data SRAM responder with 1-cycle read, range error flag and access counters
module data_sram_responder #(
   parameter int unsigned ADDR_W      = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter bit          WRITE_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        oob_err,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   // Span kept 33 bits wide so the range compare works even for the largest ADDR_W.
   localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

   logic [31:0]       mem [DEPTH];

   logic [31:0]       off;
   logic              in_range;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       old_word;
   logic [31:0]       new_word;
   logic              wr_en;
   logic              unused_ok;

   logic [31:0]       rdata_q, rdata_d;
   logic              oob_err_q, oob_err_d;
   logic [31:0]       rd_count_q, rd_count_d;
   logic [31:0]       wr_count_q, wr_count_d;

   always_comb begin
      off      = data_sram_addr - BASE_ADDR;
      in_range = {1'b0, off} < SPAN;
      idx      = off[ADDR_W+1:2];
      old_word = mem[idx];
      new_word = old_word;
      for (int i = 0; i < 4; i++) begin
         if (data_sram_we[i]) begin
            new_word[8*i +: 8] = data_sram_wdata[8*i +: 8];
         end
      end
      wr_en = data_sram_en && in_range && (data_sram_we != 4'h0);
   end

   assign unused_ok = &{1'b0, off[1:0]};

   always_comb begin
      rdata_d    = rdata_q;
      oob_err_d  = oob_err_q;
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (data_sram_en) begin
         if (!in_range) begin
            rdata_d   = 32'h0;
            oob_err_d = 1'b1;
         end else if (data_sram_we == 4'h0) begin
            rdata_d    = old_word;
            rd_count_d = rd_count_q + 32'd1;
         end else begin
            rdata_d    = WRITE_FIRST ? new_word : old_word;
            wr_count_d = wr_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_q    <= 32'h0;
         oob_err_q  <= 1'b0;
         rd_count_q <= 32'h0;
         wr_count_q <= 32'h0;
      end else begin
         rdata_q    <= rdata_d;
         oob_err_q  <= oob_err_d;
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Array is never reset; requests seen while resetn is low must not write it.
   always_ff @(posedge clk) begin
      if (resetn && wr_en) begin
         mem[idx] <= new_word;
      end
   end

   assign data_sram_rdata = rdata_q;
   assign oob_err         = oob_err_q;
   assign rd_count        = rd_count_q;
   assign wr_count        = wr_count_q;

endmodule
